// File: rtl/mux2.sv
// 2:1 word-select multiplexer for datapath operand/writeback selection.
// REG_OUT chooses a registered (1-cycle) or purely combinational output.
module mux2 #(
    parameter int unsigned          WIDTH       = 32,
    parameter bit                   REG_OUT     = 1'b1,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] sel_data_c;

    // Plain ?: keeps per-bit X-merge semantics when sel is unknown.
    assign sel_data_c = sel ? b : a;

    generate
        if (REG_OUT) begin : g_reg
            // Loads every cycle; reset wins over any data/select value.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out <= RESET_VALUE;
                end else begin
                    out <= sel_data_c;
                end
            end
        end else begin : g_comb
            // Zero-latency build: clock, reset and reset value are intentionally unused.
            logic unused_c;
            assign unused_c = ^{clk, rst_n, RESET_VALUE};
            assign out      = sel_data_c;
        end
    endgenerate

endmodule

// File: tb/tb_mux2.sv
// Bench for mux2: registered build checked cycle by cycle against a reference
// model, combinational build checked in the same timestep.
module tb_mux2;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             clk_low;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_comb;

    int n_checks;
    int n_fail;

    // Reference state: value the registered output must show after the last edge.
    logic [WIDTH-1:0] model_q;

    mux2 #(.WIDTH(WIDTH), .REG_OUT(1'b1), .RESET_VALUE('0)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .out   (out_reg)
    );

    mux2 #(.WIDTH(WIDTH), .REG_OUT(1'b0), .RESET_VALUE('0)) u_comb (
        .clk   (clk_low),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .out   (out_comb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] da,
                                              input logic [WIDTH-1:0] db,
                                              input logic             s);
        logic [WIDTH-1:0] chosen [2];
        chosen[0] = da;
        chosen[1] = db;
        return chosen[int'(s)];
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs, confirm the combinational build immediately and that the
    // registered output holds, then clock once and confirm the new value.
    task automatic step(input string tag, input logic [WIDTH-1:0] da,
                        input logic [WIDTH-1:0] db, input logic s, input logic r);
        logic [WIDTH-1:0] held;
        held  = model_q;
        a     = da;
        b     = db;
        sel   = s;
        rst_n = r;
        #1;
        check({tag, "_comb"}, out_comb, pick(da, db, s));
        if (held !== 'x) check({tag, "_hold"}, out_reg, held);
        @(posedge clk);
        model_q = r ? pick(da, db, s) : '0;
        #1;
        check(tag, out_reg, model_q);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_q  = 'x;
        clk_low  = 1'b0;
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        sel      = 1'b0;
        @(posedge clk);
        #1;

        // Reset holds output at zero regardless of select, releases with no extra cycle.
        step("rst0", 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0);
        step("rst1", 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0);
        step("rel",  32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1);

        step("aa_s0", 32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b1);
        step("aa_s1", 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1);
        step("12_s0", 32'h12345678, 32'h87654321, 1'b0, 1'b1);
        step("12_s1", 32'h12345678, 32'h87654321, 1'b1, 1'b1);
        step("de_s0", 32'hDEADBEEF, 32'hCAFEBABE, 1'b0, 1'b1);
        step("de_s1", 32'hDEADBEEF, 32'hCAFEBABE, 1'b1, 1'b1);
        step("mid_rst_s1", 32'hDEADBEEF, 32'hCAFEBABE, 1'b1, 1'b0);
        step("mid_rst_s0", 32'hDEADBEEF, 32'hCAFEBABE, 1'b0, 1'b0);
        step("mid_rel",    32'hDEADBEEF, 32'hCAFEBABE, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            step("toggle", 32'hFFFFFFFF, 32'h00000000, 1'(i % 2), 1'b1);
        end

        // Glitches on a between edges must not reach the registered output.
        step("glitch_pre", 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
        a = 32'h0F0F0F0F;
        #1;
        check("glitch_mid0", out_reg, 32'hFFFFFFFF);
        a = 32'h13572468;
        #1;
        check("glitch_mid1", out_reg, 32'hFFFFFFFF);
        check("glitch_comb", out_comb, 32'h13572468);
        @(posedge clk);
        model_q = 32'h13572468;
        #1;
        check("glitch_post", out_reg, model_q);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 60; i++) begin
            step("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
